// File: rtl/fake_jpeg_15314_launch_stage.sv
// Registered launch/capture stage around the fake_jpeg_15314_n_89 netlist: 2-entry stimulus FIFO,
// drive register, programmable settle wait, tagged result handshake. Optional parity: FAKE_JPEG_15314_PARITY_EN.
module fake_jpeg_15314_launch_stage #(
  parameter int SETTLE = 2,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [26:0]      in_vec,
  output logic [26:0]      drv_n,
  input  logic             n_89,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_bit,
  output logic [TAG_W-1:0] res_tag
`ifdef FAKE_JPEG_15314_PARITY_EN
  ,
  input  logic             in_par,
  output logic             par_err
`endif
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [26:0] mem [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic [3:0]  cnt_q;
  logic        accept, par_ok, push, pop, sample, done;

  // No pass-through: a full FIFO refuses even if the FSM pops this cycle.
  assign in_ready = (count != 2'd2) && !rst;
  assign accept   = in_valid && in_ready;

`ifdef FAKE_JPEG_15314_PARITY_EN
  assign par_ok = ~^{in_vec, in_par};
`else
  assign par_ok = 1'b1;
`endif

  assign push      = accept && par_ok;
  assign res_valid = (state_q == S_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    sample  = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count != 2'd0) begin
          pop     = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          sample  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage needs no reset; occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_vec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      drv_n   <= '0;
      cnt_q   <= 4'd0;
      res_bit <= 1'b0;
      res_tag <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (pop) begin
        drv_n <= mem[rd_ptr];
        cnt_q <= CNT_INIT;
      end else if (state_q == S_SETTLE && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (sample) res_bit <= n_89;
      if (done)   res_tag <= res_tag + TAG_W'(1);
    end
  end

`ifdef FAKE_JPEG_15314_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err <= 1'b0;
    else     par_err <= accept && !par_ok;
  end
`endif

endmodule
